// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle controller that borrows the shared 16-bit ALU (NOR/ADD/PASS-A/SHR-B)
// to run SUB, AND, NEG and MUL. Each command is broken into one ALU micro-op per
// cycle. Every intermediate result is captured at the clock edge. The final
// result is presented on a valid/ready response channel.
module alu_op_sequencer #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [2:0]            rsp_flag,
   output logic [DATA_WIDTH-1:0] alu_in1,
   output logic [DATA_WIDTH-1:0] alu_in2,
   output logic [1:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic [2:0]            alu_flag
);

   // Sequencer states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // ALU opcodes
   localparam logic [1:0] ALU_NOR  = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_PASS = 2'b10;
   localparam logic [1:0] ALU_SHR  = 2'b11;

   // Command opcodes
   localparam logic [1:0] CMD_SUB = 2'b00;
   localparam logic [1:0] CMD_AND = 2'b01;
   localparam logic [1:0] CMD_MUL = 2'b10;
   localparam logic [1:0] CMD_NEG = 2'b11;

   // MUL loop phases. PH_ITER is the loop head. It chooses PASS when the
   // multiplier is exhausted, the add step when mp[0] is set, and otherwise
   // goes straight to the doubling step.
   localparam logic [1:0] PH_ITER = 2'd0;
   localparam logic [1:0] PH_B    = 2'd1;
   localparam logic [1:0] PH_C    = 2'd2;

   localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] ZERO = '0;

   // Flag layout: [2]=zero, [1]=neg, [0]=carry
   logic [1:0]            state_reg, state_next;
   logic [1:0]            op_reg, op_next;
   logic [1:0]            step_reg, step_next;
   logic [1:0]            phase_reg, phase_next;
   // a_reg doubles as the MUL multiplicand and b_reg as the multiplier.
   // t_reg holds the temporary value, or the accumulator for MUL.
   logic [DATA_WIDTH-1:0] a_reg, a_next;
   logic [DATA_WIDTH-1:0] b_reg, b_next;
   logic [DATA_WIDTH-1:0] t_reg, t_next;
   logic [DATA_WIDTH-1:0] u_reg, u_next;
   // cy_reg is the sticky carry for SUB and the product-overflow bit for MUL.
   logic                  cy_reg, cy_next;
   logic                  mc_ovf_reg, mc_ovf_next;
   logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
   logic [2:0]            rsp_flag_reg, rsp_flag_next;

   assign cmd_ready = (state_reg == ST_IDLE);
   assign rsp_valid = (state_reg == ST_RESP);
   assign rsp_data  = rsp_data_reg;
   assign rsp_flag  = rsp_flag_reg;

   // Next-state, micro-op selection and ALU drive for the current cycle
   always_comb begin
      state_next    = state_reg;
      op_next       = op_reg;
      step_next     = step_reg;
      phase_next    = phase_reg;
      a_next        = a_reg;
      b_next        = b_reg;
      t_next        = t_reg;
      u_next        = u_reg;
      cy_next       = cy_reg;
      mc_ovf_next   = mc_ovf_reg;
      rsp_data_next = rsp_data_reg;
      rsp_flag_next = rsp_flag_reg;
      alu_op        = ALU_PASS;
      alu_in1       = ZERO;
      alu_in2       = ZERO;

      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_next     = cmd_op;
               a_next      = cmd_a;
               b_next      = cmd_b;
               t_next      = ZERO;
               u_next      = ZERO;
               cy_next     = 1'b0;
               mc_ovf_next = 1'b0;
               step_next   = 2'd0;
               phase_next  = PH_ITER;
               state_next  = ST_EXEC;
            end
         end

         ST_EXEC: begin
            case (op_reg)
               CMD_SUB: begin
                  case (step_reg)
                     2'd0: begin
                        // t = ~b
                        alu_op    = ALU_NOR;
                        alu_in1   = b_reg;
                        alu_in2   = b_reg;
                        t_next    = alu_out;
                        step_next = 2'd1;
                     end
                     2'd1: begin
                        // t = -b; the carry only appears when b was 0
                        alu_op    = ALU_ADD;
                        alu_in1   = t_reg;
                        alu_in2   = ONE;
                        t_next    = alu_out;
                        cy_next   = alu_flag[0];
                        step_next = 2'd2;
                     end
                     default: begin
                        // r = a + (-b); carry out means no borrow
                        alu_op        = ALU_ADD;
                        alu_in1       = a_reg;
                        alu_in2       = t_reg;
                        rsp_data_next = alu_out;
                        rsp_flag_next = {alu_flag[2:1], cy_reg | alu_flag[0]};
                        state_next    = ST_RESP;
                     end
                  endcase
               end

               CMD_AND: begin
                  case (step_reg)
                     2'd0: begin
                        alu_op    = ALU_NOR;
                        alu_in1   = a_reg;
                        alu_in2   = a_reg;
                        t_next    = alu_out;
                        step_next = 2'd1;
                     end
                     2'd1: begin
                        alu_op    = ALU_NOR;
                        alu_in1   = b_reg;
                        alu_in2   = b_reg;
                        u_next    = alu_out;
                        step_next = 2'd2;
                     end
                     default: begin
                        // De Morgan: a & b = ~(~a | ~b)
                        alu_op        = ALU_NOR;
                        alu_in1       = t_reg;
                        alu_in2       = u_reg;
                        rsp_data_next = alu_out;
                        rsp_flag_next = alu_flag;
                        state_next    = ST_RESP;
                     end
                  endcase
               end

               CMD_NEG: begin
                  if (step_reg == 2'd0) begin
                     alu_op    = ALU_NOR;
                     alu_in1   = a_reg;
                     alu_in2   = a_reg;
                     t_next    = alu_out;
                     step_next = 2'd1;
                  end else begin
                     alu_op        = ALU_ADD;
                     alu_in1       = t_reg;
                     alu_in2       = ONE;
                     rsp_data_next = alu_out;
                     rsp_flag_next = alu_flag;
                     state_next    = ST_RESP;
                  end
               end

               default: begin  // CMD_MUL: shift-and-add
                  case (phase_reg)
                     PH_ITER: begin
                        if (b_reg == ZERO) begin
                           // Multiplier exhausted: pass the accumulator out
                           alu_op        = ALU_PASS;
                           alu_in1       = t_reg;
                           rsp_data_next = alu_out;
                           rsp_flag_next = {alu_flag[2:1], cy_reg};
                           state_next    = ST_RESP;
                        end else if (b_reg[0]) begin
                           // acc += mc; a wrapped multiplicand also overflows the product
                           alu_op     = ALU_ADD;
                           alu_in1    = t_reg;
                           alu_in2    = a_reg;
                           t_next     = alu_out;
                           cy_next    = cy_reg | alu_flag[0] | mc_ovf_reg;
                           phase_next = PH_B;
                        end else begin
                           alu_op      = ALU_ADD;
                           alu_in1     = a_reg;
                           alu_in2     = a_reg;
                           a_next      = alu_out;
                           mc_ovf_next = mc_ovf_reg | alu_flag[0];
                           phase_next  = PH_C;
                        end
                     end
                     PH_B: begin
                        // mc = 2*mc; remember any bit shifted out of 16 bits
                        alu_op      = ALU_ADD;
                        alu_in1     = a_reg;
                        alu_in2     = a_reg;
                        a_next      = alu_out;
                        mc_ovf_next = mc_ovf_reg | alu_flag[0];
                        phase_next  = PH_C;
                     end
                     default: begin
                        // mp = mp >> 1
                        alu_op     = ALU_SHR;
                        alu_in1    = ZERO;
                        alu_in2    = b_reg;
                        b_next     = alu_out;
                        phase_next = PH_ITER;
                     end
                  endcase
               end
            endcase
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         op_reg       <= 2'd0;
         step_reg     <= 2'd0;
         phase_reg    <= PH_ITER;
         a_reg        <= '0;
         b_reg        <= '0;
         t_reg        <= '0;
         u_reg        <= '0;
         cy_reg       <= 1'b0;
         mc_ovf_reg   <= 1'b0;
         rsp_data_reg <= '0;
         rsp_flag_reg <= 3'b000;
      end else begin
         state_reg    <= state_next;
         op_reg       <= op_next;
         step_reg     <= step_next;
         phase_reg    <= phase_next;
         a_reg        <= a_next;
         b_reg        <= b_next;
         t_reg        <= t_next;
         u_reg        <= u_next;
         cy_reg       <= cy_next;
         mc_ovf_reg   <= mc_ovf_next;
         rsp_data_reg <= rsp_data_next;
         rsp_flag_reg <= rsp_flag_next;
      end
   end

endmodule
